ret_addr_stack: RTL and testbench

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/ras_pkg.sv | 16 +
 rtl/ras_mem.sv | 27 ++
 rtl/ret_addr_stack.sv | 169 ++++++++++++++++
 tb/tb_ret_addr_stack.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared op encoding and pointer-width helper for the return address stack
package ras_pkg;

    typedef enum logic [2:0] {
        RAS_NOP   = 3'd0,
        RAS_PUSH  = 3'd1,
        RAS_POP   = 3'd2,
        RAS_REPL  = 3'd3,
        RAS_FLUSH = 3'd4
    } ras_op_e;

    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ras_mem.sv
// rtl/ras_mem.sv - DEPTH x WIDTH register array, one write port, asynchronous read
module ras_mem
    import ras_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [ras_ptr_w(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]            wdata_i,
    input  logic [ras_ptr_w(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]            rdata_o
);

    // Small array: keep it in flops so the read can stay combinational.
    (* ram_style = "logic" *) logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ret_addr_stack.sv
// rtl/ret_addr_stack.sv - return address stack top; RAS_ERR_FLAGS_EN enables sticky overflow/underflow flags
module ret_addr_stack
    import ras_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clr
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             is_empty, is_full;
    ras_op_e          op;
    logic [PTR_W-1:0] ptr_inc, ptr_dec;
    logic             mem_we;
    logic [PTR_W-1:0] mem_waddr;
    logic [WIDTH-1:0] mem_rdata;
    logic             ovf_evt, udf_evt;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign ptr_inc  = ptr_q + 1'b1;
    assign ptr_dec  = ptr_q - 1'b1;

    // A replace on an empty stack has nothing to replace, so it becomes a push.
    always_comb begin
        op = RAS_NOP;
        if (flush) begin
            op = RAS_FLUSH;
        end else if (push && pop) begin
            op = is_empty ? RAS_PUSH : RAS_REPL;
        end else if (push) begin
            op = RAS_PUSH;
        end else if (pop) begin
            op = RAS_POP;
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        ovf_evt   = 1'b0;
        udf_evt   = 1'b0;
        if (en) begin
            case (op)
                RAS_FLUSH: begin
                    ptr_d   = '0;
                    count_d = '0;
                end
                RAS_REPL: begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    dout_d    = data_in;
                end
                RAS_PUSH: begin
                    if (!is_full) begin
                        ptr_d     = ptr_inc;
                        mem_we    = 1'b1;
                        mem_waddr = ptr_inc;
                        count_d   = count_q + 1'b1;
                        dout_d    = data_in;
                    end else begin
                        ovf_evt = 1'b1;
                        // When full, the slot after the top holds the oldest entry.
                        if (WRAP_MODE != 0) begin
                            ptr_d     = ptr_inc;
                            mem_we    = 1'b1;
                            mem_waddr = ptr_inc;
                            dout_d    = data_in;
                        end
                    end
                end
                RAS_POP: begin
                    if (!is_empty) begin
                        ptr_d   = ptr_dec;
                        count_d = count_q - 1'b1;
                        dout_d  = mem_rdata;
                    end else begin
                        udf_evt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ras_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we && !rst),
        .waddr_i (mem_waddr),
        .wdata_i (data_in),
        .raddr_i (ptr_dec),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

`ifdef RAS_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Clear is not qualified by en; a same-edge error re-sets the flag.
    always_comb begin
        ovf_d = (err_clr ? 1'b0 : ovf_q) | ovf_evt;
        udf_d = (err_clr ? 1'b0 : udf_q) | udf_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    logic [2:0] unused_flag_bits;
    assign unused_flag_bits = {err_clr, ovf_evt, udf_evt};
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

    assign data_out = dout_q;
    assign count    = count_q;
    assign empty    = is_empty;
    assign full     = is_full;

endmodule

// File: tb/tb_ret_addr_stack.sv
// tb/tb_ret_addr_stack.sv - directed and random checks of ret_addr_stack in wrap and saturate modes
module tb_ret_addr_stack;

    localparam int W = 32;
    localparam int D = 4;
`ifdef RAS_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b1, push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] dout_w, dout_s;
    logic [2:0]   cnt_w, cnt_s;
    logic         empty_w, empty_s, full_w, full_s;
    logic         ovf_w, ovf_s, udf_w, udf_s;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ret_addr_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(1)) dut_w (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .flush(flush),
        .data_in(data_in), .data_out(dout_w), .count(cnt_w), .empty(empty_w),
        .full(full_w), .overflow(ovf_w), .underflow(udf_w), .err_clr(err_clr)
    );

    ret_addr_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(0)) dut_s (
        .clk(clk), .rst(rst), .en(en), .push(push), .pop(pop), .flush(flush),
        .data_in(data_in), .data_out(dout_s), .count(cnt_s), .empty(empty_s),
        .full(full_s), .overflow(ovf_s), .underflow(udf_s), .err_clr(err_clr)
    );

    // Reference: entries kept bottom-first in st[d][0..n-1]; d=0 wraps, d=1 saturates.
    logic [W-1:0] st [2][D];
    int           n [2];
    logic [W-1:0] m_dout [2];
    bit           m_known [2];
    bit           m_ovf [2], m_udf [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            n[d] = 0; m_dout[d] = '0; m_known[d] = 1'b1;
            m_ovf[d] = 1'b0; m_udf[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (err_clr) begin
                m_ovf[d] = 1'b0; m_udf[d] = 1'b0;
            end
            if (en) begin
                if (flush) begin
                    n[d] = 0;
                end else if (push && pop && n[d] > 0) begin
                    st[d][n[d]-1] = data_in;
                    m_dout[d] = data_in; m_known[d] = 1'b1;
                end else if (push) begin
                    if (n[d] < D) begin
                        st[d][n[d]] = data_in; n[d]++;
                        m_dout[d] = data_in; m_known[d] = 1'b1;
                    end else begin
                        m_ovf[d] = 1'b1;
                        if (d == 0) begin
                            for (int i = 0; i < D - 1; i++) st[d][i] = st[d][i+1];
                            st[d][D-1] = data_in;
                            m_dout[d] = data_in; m_known[d] = 1'b1;
                        end
                    end
                end else if (pop) begin
                    if (n[d] > 0) begin
                        n[d]--;
                        if (n[d] > 0) m_dout[d] = st[d][n[d]-1];
                        else m_known[d] = 1'b0;
                    end else begin
                        m_udf[d] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        chk({step, " w.count"}, W'(cnt_w), W'(n[0]));
        chk({step, " s.count"}, W'(cnt_s), W'(n[1]));
        chk({step, " w.empty"}, W'(empty_w), W'(n[0] == 0));
        chk({step, " s.empty"}, W'(empty_s), W'(n[1] == 0));
        chk({step, " w.full"}, W'(full_w), W'(n[0] == D));
        chk({step, " s.full"}, W'(full_s), W'(n[1] == D));
        if (m_known[0]) chk({step, " w.data_out"}, dout_w, m_dout[0]);
        if (m_known[1]) chk({step, " s.data_out"}, dout_s, m_dout[1]);
        chk({step, " w.overflow"}, W'(ovf_w), W'(m_ovf[0] & FLAGS));
        chk({step, " s.overflow"}, W'(ovf_s), W'(m_ovf[1] & FLAGS));
        chk({step, " w.underflow"}, W'(udf_w), W'(m_udf[0] & FLAGS));
        chk({step, " s.underflow"}, W'(udf_s), W'(m_udf[1] & FLAGS));
    endtask

    task automatic cyc(input string step, input bit p, input bit o, input bit f,
                       input bit e, input bit c, input logic [W-1:0] din);
        push = p; pop = o; flush = f; en = e; err_clr = c; data_in = din;
        @(posedge clk);
        model_step();
        #1;
        check_all(step);
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        cyc("push10", 1, 0, 0, 1, 0, 32'h10);
        cyc("push20", 1, 0, 0, 1, 0, 32'h20);
        cyc("push30", 1, 0, 0, 1, 0, 32'h30);
        chk("basic top", dout_w, 32'h30);
        cyc("pop", 0, 1, 0, 1, 0, 32'h0);
        chk("basic pop", dout_w, 32'h20);

        cyc("repl", 1, 1, 0, 1, 0, 32'hAA);
        chk("repl value", dout_w, 32'hAA);
        cyc("pop_after_repl", 0, 1, 0, 1, 0, 32'h0);
        chk("below repl", dout_w, 32'h10);

        cyc("push_a", 1, 0, 0, 1, 0, 32'h44);
        cyc("push_b", 1, 0, 0, 1, 0, 32'h55);
        cyc("flush_push", 1, 0, 1, 1, 0, 32'h66);
        cyc("stall_push", 1, 0, 0, 0, 0, 32'h77);

        for (int i = 1; i <= 5; i++) cyc($sformatf("fill%0d", i), 1, 0, 0, 1, 0, W'(i));
        chk("sat top held", dout_s, 32'h4);
        chk("wrap top", dout_w, 32'h5);
        for (int i = 1; i <= 5; i++) cyc($sformatf("drain%0d", i), 0, 1, 0, 1, 0, 32'h0);
        cyc("clr_stalled", 0, 0, 0, 0, 1, 32'h0);
        cyc("clr_vs_err", 0, 1, 0, 1, 1, 32'h0);
        cyc("clr", 0, 0, 0, 1, 1, 32'h0);

        for (int k = 0; k < 300; k++) begin
            cyc($sformatf("rnd%0d", k),
                $urandom_range(9, 0) < 6, $urandom_range(1, 0) == 1,
                $urandom_range(15, 0) == 0, $urandom_range(7, 0) != 0,
                $urandom_range(15, 0) == 0, $urandom);
        end

        cyc("pre_rst_a", 1, 0, 0, 1, 0, 32'hC0DE);
        push = 1'b1; pop = 1'b0; flush = 1'b0; en = 1'b1; err_clr = 1'b0; data_in = 32'hBEEF;
        #2 rst = 1'b1;
        model_reset();
        #1 check_all("rst_async");
        @(posedge clk);
        #1 check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        cyc("post_rst_pop", 0, 1, 0, 1, 0, 32'h0);
        cyc("post_rst_push", 1, 0, 0, 1, 0, 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
